// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: two-requester round-robin arbiter and sequencer for the
// RW port (port 0) of a 1024 x 8 OpenRAM macro. All macro pins are registered;
// read data returns to the originating requester two cycles after acceptance.
// Optional feature: define SRAM_ARB_CLEAR_EN to zero the whole macro after
// reset before any request is accepted.
module sram_port0_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_WMASKS = 1
) (
    input  logic                  clk0,
    input  logic                  rst_n,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    input  logic [NUM_WMASKS-1:0] a_req_wmask,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    input  logic [NUM_WMASKS-1:0] b_req_wmask,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,

    output logic                  init_done,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    logic                  clearing_c;
    logic [ADDR_WIDTH-1:0] clr_addr_c;

`ifdef SRAM_ARB_CLEAR_EN
    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    // State and sweep-address register; reset always restarts the sweep at 0
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Sweep one address per cycle, leave CLEAR after the last word is issued
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    assign clearing_c = (state_q == ST_CLEAR);
    assign clr_addr_c = clr_cnt_q;
    assign init_done  = (state_q == ST_RUN);
`else
    assign clearing_c = 1'b0;
    assign clr_addr_c = '0;
    assign init_done  = 1'b1;
`endif

    // Round-robin pointer: 0 favours A, 1 favours B
    logic ptr_q, ptr_d;

    // Macro pin registers
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    // Read return pipeline: stage 1 = macro capturing, stage 2 = dout valid
    logic p1_vld_q, p1_vld_d, p1_id_q, p1_id_d;
    logic p2_vld_q, p2_vld_d, p2_id_q, p2_id_d;

    // Response registers
    logic                  a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    // Grant/accept decode and selected request fields
    logic                  run_c, grant_a_c, grant_b_c, acc_a_c, acc_b_c, acc_c;
    logic                  sel_we_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;
    logic [NUM_WMASKS-1:0] sel_wmask_c;

    assign run_c       = rst_n & init_done & ~clearing_c;
    assign grant_a_c   = a_req_valid & (~b_req_valid | ~ptr_q);
    assign grant_b_c   = b_req_valid & (~a_req_valid | ptr_q);
    assign a_req_ready = run_c & grant_a_c;
    assign b_req_ready = run_c & grant_b_c;
    assign acc_a_c     = a_req_valid & a_req_ready;
    assign acc_b_c     = b_req_valid & b_req_ready;
    assign acc_c       = acc_a_c | acc_b_c;

    // Next-state for pointer, macro pins, return pipeline and responses
    always_comb begin
        sel_we_c    = a_req_we;
        sel_addr_c  = a_req_addr;
        sel_wdata_c = a_req_wdata;
        sel_wmask_c = a_req_wmask;
        ptr_d       = ptr_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        wmask_d     = '0;
        addr_d      = addr_q;
        din_d       = din_q;
        p1_vld_d    = 1'b0;
        p1_id_d     = 1'b0;
        p2_vld_d    = p1_vld_q;
        p2_id_d     = p1_id_q;
        a_vld_d     = p2_vld_q & ~p2_id_q;
        b_vld_d     = p2_vld_q & p2_id_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;

        if (acc_b_c) begin
            sel_we_c    = b_req_we;
            sel_addr_c  = b_req_addr;
            sel_wdata_c = b_req_wdata;
            sel_wmask_c = b_req_wmask;
        end

        if (acc_a_c) begin
            ptr_d = 1'b1;
        end else if (acc_b_c) begin
            ptr_d = 1'b0;
        end

        if (clearing_c) begin
            csb_d   = 1'b0;
            web_d   = 1'b0;
            wmask_d = '1;
            addr_d  = clr_addr_c;
            din_d   = '0;
        end else if (acc_c) begin
            csb_d    = 1'b0;
            web_d    = ~sel_we_c;
            wmask_d  = sel_we_c ? sel_wmask_c : '0;
            addr_d   = sel_addr_c;
            din_d    = sel_wdata_c;
            p1_vld_d = ~sel_we_c;
            p1_id_d  = acc_b_c;
        end

        if (a_vld_d) begin
            a_rdata_d = sram_dout0;
        end
        if (b_vld_d) begin
            b_rdata_d = sram_dout0;
        end
    end

    // Register stage for all of the above; reset flushes in-flight reads
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= 1'b0;
            csb_q     <= 1'b1;
            web_q     <= 1'b1;
            wmask_q   <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            p1_vld_q  <= 1'b0;
            p1_id_q   <= 1'b0;
            p2_vld_q  <= 1'b0;
            p2_id_q   <= 1'b0;
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            csb_q     <= csb_d;
            web_q     <= web_d;
            wmask_q   <= wmask_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            p1_vld_q  <= p1_vld_d;
            p1_id_q   <= p1_id_d;
            p2_vld_q  <= p2_vld_d;
            p2_id_q   <= p2_id_d;
            a_vld_q   <= a_vld_d;
            b_vld_q   <= b_vld_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;
    assign a_rsp_valid = a_vld_q;
    assign a_rsp_rdata = a_rdata_q;
    assign b_rsp_valid = b_vld_q;
    assign b_rsp_rdata = b_rdata_q;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Testbench for sram_port0_arbiter: behavioural macro, a transaction-level
// reference (memory image + response queue + fairness rule) checked every
// cycle on the falling edge, plus directed literal checks.
module tb_sram_port0_arbiter;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1024;

    typedef struct packed {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          wm;
    } op_t;

    typedef struct {
        int            due;
        bit            is_b;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk0 = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req_valid = 1'b0, b_req_valid = 1'b0;
    logic          a_req_ready, b_req_ready;
    logic          a_req_we = 1'b0, b_req_we = 1'b0;
    logic [AW-1:0] a_req_addr = '0, b_req_addr = '0;
    logic [DW-1:0] a_req_wdata = '0, b_req_wdata = '0;
    logic [0:0]    a_req_wmask = '0, b_req_wmask = '0;
    logic          a_rsp_valid, b_rsp_valid;
    logic [DW-1:0] a_rsp_rdata, b_rsp_rdata;
    logic          init_done;
    logic          sram_csb0, sram_web0;
    logic [0:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port0_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(1)) dut (
        .clk0(clk0), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_wmask(a_req_wmask),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_wmask(b_req_wmask),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk0 = ~clk0;

    // Behavioural macro: captures pins on the rising edge, dout follows a read
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge clk0) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                if (sram_wmask0[0]) sram_mem[sram_addr0] <= sram_din0;
            end else begin
                sram_dout0 <= sram_mem[sram_addr0];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state
    logic [DW-1:0] ref_mem [DEPTH];
    rsp_t          rq[$];
    int            cyc = 0;
    int            clr_idx;
    bit            exp_init, last_a;
    bit            p_csb, p_web, p_wm;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_din;
    logic [DW-1:0] exp_ad, exp_bd;
    bit            exp_av, exp_bv, win_b, any_v, exp_ra, exp_rb;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = DW'(i) ^ 8'h5A;
            ref_mem[i]  = DW'(i) ^ 8'h5A;
        end
    end

    // Per-cycle compare of every output against the reference, then advance it
    always @(negedge clk0) begin
        if (!rst_n) begin
            rq.delete();
            p_csb = 1; p_web = 1; p_wm = 0; p_addr = '0; p_din = '0;
            exp_ad = '0; exp_bd = '0; last_a = 0;
`ifdef SRAM_ARB_CLEAR_EN
            exp_init = 0; clr_idx = 0;
`else
            exp_init = 1; clr_idx = -1;
`endif
        end

        // Fairness: a lone requester wins; with both, the one not served last
        any_v  = a_req_valid || b_req_valid;
        win_b  = (a_req_valid && b_req_valid) ? last_a : b_req_valid;
        exp_ra = rst_n && exp_init && any_v && !win_b;
        exp_rb = rst_n && exp_init && any_v && win_b;

        exp_av = 0; exp_bv = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].is_b) begin exp_bv = 1; exp_bd = rq[0].data; end
            else            begin exp_av = 1; exp_ad = rq[0].data; end
            void'(rq.pop_front());
        end

        chk("init_done",   32'(init_done),   32'(exp_init));
        chk("a_req_ready", 32'(a_req_ready), 32'(exp_ra));
        chk("b_req_ready", 32'(b_req_ready), 32'(exp_rb));
        chk("sram_csb0",   32'(sram_csb0),   32'(p_csb));
        chk("sram_web0",   32'(sram_web0),   32'(p_web));
        chk("sram_wmask0", 32'(sram_wmask0), 32'(p_wm));
        chk("sram_addr0",  32'(sram_addr0),  32'(p_addr));
        chk("sram_din0",   32'(sram_din0),   32'(p_din));
        chk("a_rsp_valid", 32'(a_rsp_valid), 32'(exp_av));
        chk("b_rsp_valid", 32'(b_rsp_valid), 32'(exp_bv));
        chk("a_rsp_rdata", 32'(a_rsp_rdata), 32'(exp_ad));
        chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'(exp_bd));

        if (rst_n) begin
            if (clr_idx >= 0) begin
                p_csb = 0; p_web = 0; p_wm = 1; p_addr = AW'(clr_idx); p_din = '0;
                ref_mem[clr_idx] = '0;
                clr_idx++;
                if (clr_idx == DEPTH) begin clr_idx = -1; exp_init = 1; end
            end else if (exp_ra || exp_rb) begin
                logic          we, wm;
                logic [AW-1:0] ad;
                logic [DW-1:0] wd;
                we = exp_rb ? b_req_we    : a_req_we;
                wm = exp_rb ? b_req_wmask[0] : a_req_wmask[0];
                ad = exp_rb ? b_req_addr  : a_req_addr;
                wd = exp_rb ? b_req_wdata : a_req_wdata;
                p_csb = 0; p_web = !we; p_wm = we && wm; p_addr = ad; p_din = wd;
                if (we) begin
                    if (wm) ref_mem[ad] = wd;
                end else begin
                    rq.push_back('{due: cyc + 3, is_b: exp_rb, data: ref_mem[ad]});
                end
                last_a = exp_ra;
            end else begin
                p_csb = 1; p_web = 1; p_wm = 0;
            end
        end
        cyc++;
    end

    // Present requests and hold each until its handshake completes
    task automatic issue(input op_t a, input op_t b);
        bit pa, pb, ra, rb;
        int n;
        pa = a.en; pb = b.en;
        if (pa) begin
            a_req_valid = 1; a_req_we = a.we; a_req_addr = a.addr;
            a_req_wdata = a.wd; a_req_wmask = a.wm;
        end
        if (pb) begin
            b_req_valid = 1; b_req_we = b.we; b_req_addr = b.addr;
            b_req_wdata = b.wd; b_req_wmask = b.wm;
        end
        n = 0;
        while ((pa || pb) && n < 3000) begin
            @(negedge clk0);
            ra = pa && a_req_ready;
            rb = pb && b_req_ready;
            @(posedge clk0); #1;
            if (ra) begin pa = 0; a_req_valid = 0; end
            if (rb) begin pb = 0; b_req_valid = 0; end
            n++;
        end
        if (pa || pb) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: pending a=%0d b=%0d after %0d cycles", pa, pb, n);
            a_req_valid = 0; b_req_valid = 0;
        end
    endtask

    function automatic op_t wr(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic m);
        return '{en: 1'b1, we: 1'b1, addr: ad, wd: d, wm: m};
    endfunction
    function automatic op_t rd(input logic [AW-1:0] ad);
        return '{en: 1'b1, we: 1'b0, addr: ad, wd: '0, wm: 1'b0};
    endfunction

    localparam op_t NOP = '0;

    initial begin
        op_t ta[4], tb_[4];
        int  n;

        repeat (3) @(posedge clk0);
        #1;
`ifdef SRAM_ARB_CLEAR_EN
        // B held valid from reset: no grant until the sweep completes
        b_req_valid = 1; b_req_we = 0; b_req_addr = 10'h123;
        #1 chk("ready_in_reset", 32'(b_req_ready), 32'd0);
        rst_n = 1;
        n = 0;
        while (n < 2000) begin
            @(negedge clk0);
            if (init_done) break;
            n++;
        end
        chk("clear_cycles", 32'(n), 32'd1024);
        chk("b_ready_after_clear", 32'(b_req_ready), 32'd1);
        @(posedge clk0); #1;
        b_req_valid = 0;
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        chk("clear_read_valid", 32'(b_rsp_valid), 32'd1);
        chk("clear_read_data",  32'(b_rsp_rdata), 32'h00);
`else
        // A read waiting across reset release is accepted on the first edge
        a_req_valid = 1; a_req_we = 0; a_req_addr = 10'h010;
        #1 chk("ready_in_reset", 32'(a_req_ready), 32'd0);
        rst_n = 1;
        @(negedge clk0);
        chk("first_ready", 32'(a_req_ready), 32'd1);
        chk("init_done_hi", 32'(init_done), 32'd1);
        @(posedge clk0); #1;
        a_req_valid = 0;
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        chk("first_read_valid", 32'(a_rsp_valid), 32'd1);
        chk("first_read_data",  32'(a_rsp_rdata), 32'h4A);
        @(posedge clk0); #1;
`endif

        // Preload; last service goes to B so the pointer favours A next
        issue(wr(10'h010, 8'h11, 1'b1), NOP);
        issue(wr(10'h005, 8'h3C, 1'b1), NOP);
        issue(NOP, wr(10'h020, 8'h22, 1'b1));

        // Both continuously valid: A,B,A,B grants and alternating responses
        a_req_valid = 1; a_req_we = 0; a_req_addr = 10'h010;
        b_req_valid = 1; b_req_we = 0; b_req_addr = 10'h020;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk0);
            if (i < 8) begin
                chk("alt_a_ready", 32'(a_req_ready), 32'((i % 2) == 0));
                chk("alt_b_ready", 32'(b_req_ready), 32'((i % 2) == 1));
            end
            if (i >= 3) begin
                chk("alt_a_rsp", 32'(a_rsp_valid), 32'(((i - 3) % 2) == 0));
                chk("alt_b_rsp", 32'(b_rsp_valid), 32'(((i - 3) % 2) == 1));
                if (a_rsp_valid) chk("alt_a_data", 32'(a_rsp_rdata), 32'h11);
                if (b_rsp_valid) chk("alt_b_data", 32'(b_rsp_rdata), 32'h22);
            end
            @(posedge clk0); #1;
            if (i == 7) begin a_req_valid = 0; b_req_valid = 0; end
        end

        // Back-to-back write then read of the top address
        issue(wr(10'h3FF, 8'hA5, 1'b1), NOP);
        issue(rd(10'h3FF), NOP);
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        chk("wr_rd_valid",   32'(a_rsp_valid), 32'd1);
        chk("wr_rd_data",    32'(a_rsp_rdata), 32'hA5);
        chk("wr_rd_b_quiet", 32'(b_rsp_valid), 32'd0);
        @(posedge clk0); #1;

        // Write with mask 0 leaves the word untouched
        issue(wr(10'h005, 8'hFF, 1'b0), NOP);
        chk("mask0_pin_wmask", 32'(sram_wmask0), 32'd0);
        chk("mask0_pin_web",   32'(sram_web0),   32'd0);
        chk("mask0_pin_csb",   32'(sram_csb0),   32'd0);
        issue(rd(10'h005), NOP);
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        chk("mask0_read", 32'(a_rsp_rdata), 32'h3C);
        @(posedge clk0); #1;

        // Reset while reads are in flight: pins idle at once, responses dropped
        issue(rd(10'h010), NOP);
        issue(rd(10'h020), NOP);
        rst_n = 0;
        #1;
        chk("rst_async_csb", 32'(sram_csb0), 32'd1);
        chk("rst_async_web", 32'(sram_web0), 32'd1);
        repeat (2) @(posedge clk0);
        #1 rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk0);
            chk("rst_drop_rsp", 32'(a_rsp_valid), 32'd0);
        end
        @(posedge clk0); #1;

        // Mixed simultaneous traffic from both requesters
        ta[0] = wr(10'h100, 8'h77, 1'b1); tb_[0] = rd(10'h100);
        ta[1] = rd(10'h3FF);              tb_[1] = wr(10'h3FF, 8'h99, 1'b1);
        ta[2] = wr(10'h200, 8'hC3, 1'b1); tb_[2] = wr(10'h201, 8'h3C, 1'b1);
        ta[3] = rd(10'h200);              tb_[3] = rd(10'h201);
        for (int i = 0; i < 4; i++) issue(ta[i], tb_[i]);
        repeat (5) @(negedge clk0);
        chk("mix_a_hold", 32'(a_rsp_rdata), 32'hC3);
        chk("mix_b_hold", 32'(b_rsp_rdata), 32'h3C);

        repeat (2) @(posedge clk0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_port0_arbiter.md
# sram_port0_arbiter

Two-requester round-robin arbiter and sequencer for the RW port (port 0) of the 1 KB OpenRAM macro (1024 x 8, 1 write-mask bit). It accepts read/write requests from requesters A and B over valid/ready handshakes and drives the macro's chip-select, write-enable, mask, address and data pins from registers. It captures read data at the correct cycle and returns it to the originating requester. The macro's read-only port 1 is not driven by this block.

## Interface
- ADDR_WIDTH, 10, macro address width
- DATA_WIDTH, 8, macro data width
- NUM_WMASKS, 1, write-mask bits
- clk0  in  1  clock; also drives the macro's clk0
- rst_n  in  1  asynchronous active-low reset
- a_req_valid / b_req_valid  in  1  request present
- a_req_ready / b_req_ready  out  1  request accepted this cycle (combinational)
- a_req_we / b_req_we  in  1  1 = write, 0 = read
- a_req_addr / b_req_addr  in  ADDR_WIDTH  word address
- a_req_wdata / b_req_wdata  in  DATA_WIDTH  write data
- a_req_wmask / b_req_wmask  in  NUM_WMASKS  write byte mask
- a_rsp_valid / b_rsp_valid  out  1  one-cycle read-data strobe, no backpressure
- a_rsp_rdata / b_rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- init_done  out  1  arbiter accepting requests
- sram_csb0  out  1  macro chip select, active low
- sram_web0  out  1  macro write enable, active low
- sram_wmask0  out  NUM_WMASKS  macro write mask
- sram_addr0  out  ADDR_WIDTH  macro address
- sram_din0  out  DATA_WIDTH  macro write data
- sram_dout0  in  DATA_WIDTH  macro read data

## Operation
- FSM states: CLEAR, RUN. Reset enters CLEAR if SRAM_ARB_CLEAR_EN is defined, otherwise RUN.
- RUN:
  - Each cycle, at most one request is granted.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester indicated by the priority pointer is granted.
  - After any grant, the pointer moves to the other requester. The pointer is unchanged with no grant. Reset value points to A.
  - x_req_ready = init_done & grant_x. The handshake completes on valid & ready.
  - Requesters hold their request fields stable while valid and not ready. Ready never depends on the other requester's ready.
- On an accepted request, the registered macro pins are loaded the next edge:
  - csb0 = 0.
  - web0 = ~we.
  - wmask0 = we ? wmask : 0.
  - addr0 and din0 from the request.
- With no accepted request: csb0 = 1, web0 = 1, wmask0 = 0. addr0 and din0 hold their previous values.
- Reads push {valid, id} into a 2-stage return pipeline. Writes produce no response.
- Return stage: x_rsp_valid = 1 for exactly one cycle. x_rsp_rdata = sram_dout0 registered at that edge. The other requester's rsp_valid = 0. rsp_rdata holds its value between strobes.
- Ordering: any read accepted after a write to the same address returns the new data, including back-to-back write-then-read.
- Reset mid-operation: pins return to reset values, the return pipeline is flushed, and responses in flight are dropped.

## Timing
- Reset values of all outputs:
  - sram_csb0 = 1, sram_web0 = 1.
  - sram_wmask0 = 0, sram_addr0 = 0, sram_din0 = 0.
  - both rsp_valid = 0, both rsp_rdata = 0.
  - init_done = 0 (CLEAR build) / 1 (otherwise).
  - both req_ready = 0 while in reset.
- Request accepted at edge T: macro pins valid after T. The macro captures them at T+1.
- Read data is sampled at edge T+2. rsp_valid is high in the cycle after T+2. Read latency = 2 cycles, fully pipelined.
- Throughput: one access per cycle sustained.
- Two requesters both continuously valid alternate A, B, A, B.

## Configuration
- SRAM_ARB_CLEAR_EN defined:
  - After reset, the FSM sits in CLEAR and writes 0 to addresses 0..RAM_DEPTH-1, one per cycle (csb0 = 0, web0 = 0, wmask0 = all-ones, din0 = 0).
  - Both ready = 0 and init_done = 0 throughout.
  - After the write to address 1023, state becomes RUN and init_done = 1, 1024 cycles after reset release.
  - Reset during CLEAR restarts the sweep at address 0.
- Not defined:
  - No clear FSM; memory contents are unknown.
  - init_done = 1 from reset.
  - Requests may be accepted on the first edge after reset release.

## Test plan
- A writes 0xA5 to addr 0x3FF, then A reads 0x3FF on the next cycle -> a_rsp_valid 2 cycles after read accept, rdata = 0xA5, b_rsp_valid stays 0.
- A and B both continuously valid with reads of 0x010/0x020 (preloaded 0x11/0x22) -> grants alternate A, B, A, B starting with A after reset; responses alternate with rdata 0x11/0x22, one per cycle.
- A write with wmask = 0 to addr 5 (previous 0x3C) -> later read returns 0x3C; sram_wmask0 = 0 observed on the pins.
- Reset asserted one cycle after a read accept -> no rsp_valid is ever produced for it; pins return to csb0 = 1, web0 = 1 asynchronously.
- SRAM_ARB_CLEAR_EN build, b_req_valid held high from reset -> b_req_ready = 0 for 1024 cycles; init_done rises; reading any address returns 0x00.
- Non-CLEAR build: A reads on the first cycle after reset -> accepted immediately, and init_done = 1 throughout.
